// File: rtl/spi_read_ctrl.sv
// Read-transaction sequencer over an 8-bit SPI byte engine: CMD, 24-bit address, data burst.
// Define SPI_READ_CTRL_FAST_READ_EN for the fast-read command (8'h0B) plus one dummy byte.
module spi_read_ctrl #(
    parameter logic [7:0]  CMD_READ = 8'h03,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    output logic        done,
    output logic        cs_n,
    output logic        eng_start,
    output logic [7:0]  eng_din,
    input  logic        eng_busy,
    input  logic [7:0]  eng_dout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_ADDR,
`ifdef SPI_READ_CTRL_FAST_READ_EN
        ST_DUMMY,
`endif
        ST_DATA,
        ST_HOLD,
        ST_DESEL
    } state_e;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT_HI,
        PH_WAIT_LO
    } phase_e;

`ifdef SPI_READ_CTRL_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam logic [7:0] CMD_BYTE = CMD_READ;
`endif
    localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);
    localparam logic [3:0] IDLE_LAST  = 4'(CS_IDLE - 1);

    state_e      state_q;
    phase_e      phase_q;
    logic [3:0]  cnt_q;
    logic [8:0]  rem_q;
    logic [23:0] addr_q;
    logic [7:0]  len_q;
    logic        req_ready_q;
    logic        cs_n_q;
    logic        eng_start_q;
    logic [7:0]  eng_din_q;
    logic [7:0]  rd_data_q;
    logic        rd_valid_q;
    logic        rd_last_q;
    logic        done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_ISSUE;
            cnt_q       <= '0;
            rem_q       <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            req_ready_q <= 1'b0;
            cs_n_q      <= 1'b1;
            eng_start_q <= 1'b0;
            eng_din_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; pulse defaults here are overridden by later assignments below.
            eng_start_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        cs_n_q      <= 1'b0;
                        addr_q      <= req_addr;
                        len_q       <= req_len;
                        cnt_q       <= '0;
                        state_q     <= ST_SETUP;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_q     <= ST_CMD;
                        phase_q     <= PH_ISSUE;
                        eng_start_q <= 1'b1;
                        eng_din_q   <= CMD_BYTE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_DESEL;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                ST_DESEL: begin
                    if (cnt_q == IDLE_LAST) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                // Byte-carrying states share the issue / wait-high / wait-low handshake.
                default: begin
                    case (phase_q)
                        PH_ISSUE:   phase_q <= PH_WAIT_HI;
                        PH_WAIT_HI: if (eng_busy) phase_q <= PH_WAIT_LO;
                        default: begin
                            if (!eng_busy) begin
                                phase_q     <= PH_ISSUE;
                                eng_start_q <= 1'b1;
                                eng_din_q   <= 8'h00;
                                case (state_q)
                                    ST_CMD: begin
                                        state_q   <= ST_ADDR;
                                        eng_din_q <= addr_q[23:16];
                                        cnt_q     <= '0;
                                    end
                                    ST_ADDR: begin
                                        if (cnt_q == 4'd2) begin
`ifdef SPI_READ_CTRL_FAST_READ_EN
                                            state_q <= ST_DUMMY;
`else
                                            state_q <= ST_DATA;
                                            rem_q   <= {1'b0, len_q} + 9'd1;
`endif
                                        end else begin
                                            cnt_q     <= cnt_q + 4'd1;
                                            eng_din_q <= (cnt_q == 4'd0) ? addr_q[15:8] : addr_q[7:0];
                                        end
                                    end
`ifdef SPI_READ_CTRL_FAST_READ_EN
                                    ST_DUMMY: begin
                                        state_q <= ST_DATA;
                                        rem_q   <= {1'b0, len_q} + 9'd1;
                                    end
`endif
                                    ST_DATA: begin
                                        rd_data_q  <= eng_dout;
                                        rd_valid_q <= 1'b1;
                                        rd_last_q  <= (rem_q == 9'd1);
                                        rem_q      <= rem_q - 9'd1;
                                        if (rem_q == 9'd1) begin
                                            eng_start_q <= 1'b0;
                                            cnt_q       <= '0;
                                            state_q     <= ST_HOLD;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign cs_n      = cs_n_q;
    assign eng_start = eng_start_q;
    assign eng_din   = eng_din_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_spi_read_ctrl.sv
// Randomized bench for spi_read_ctrl: byte-engine model, transaction-level scoreboard, directed corner cases.
module tb_spi_read_ctrl;

    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 4;
`ifdef SPI_READ_CTRL_FAST_READ_EN
    localparam int         HDR         = 5;
    localparam logic [7:0] CMD         = 8'h0B;
    localparam int         BURST4_STARTS = 9;
    localparam int         MAX_STARTS  = 261;
`else
    localparam int         HDR         = 4;
    localparam logic [7:0] CMD         = 8'h03;
    localparam int         BURST4_STARTS = 8;
    localparam int         MAX_STARTS  = 260;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [7:0]  req_len;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        done;
    logic        cs_n;
    logic        eng_start;
    logic [7:0]  eng_din;
    logic        eng_busy;
    logic [7:0]  eng_dout;

    spi_read_ctrl #(
        .CMD_READ (8'h03),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .CS_IDLE  (CS_IDLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .done      (done),
        .cs_n      (cs_n),
        .eng_start (eng_start),
        .eng_din   (eng_din),
        .eng_busy  (eng_busy),
        .eng_dout  (eng_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected bus bytes, expected read bytes, expected burst lengths.
    typedef struct {
        logic [7:0] data;
        logic       last;
    } rd_exp_t;

    rd_exp_t    exp_rd_q[$];
    logic [7:0] exp_din_q[$];
    int         exp_len_q[$];
    logic [7:0] forced_q[$];
    int         model_len;

    logic [7:0] din_log[$];
    logic [7:0] rd_log[$];
    logic       last_log[$];
    int         tot_start = 0;
    int         tot_rd    = 0;
    int         tot_done  = 0;

    // Byte engine: busy rises two clocks after start, stays high 1..4 clocks, dout valid on busy fall.
    int         e_st;
    int         e_idx;
    int         e_n;
    int         e_hold;
    logic [7:0] e_din;
    logic [7:0] e_resp;

    initial begin
        eng_busy = 1'b0;
        eng_dout = 8'h00;
        e_st     = 0;
        e_idx    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                eng_busy = 1'b0;
                e_st     = 0;
                e_idx    = 0;
            end else begin
                if (cs_n && e_st == 0) e_idx = 0;
                case (e_st)
                    0: begin
                        if (eng_start) begin
                            e_din = eng_din;
                            e_n   = e_idx;
                            e_idx++;
                            if (e_n >= HDR && forced_q.size() != 0) e_resp = forced_q.pop_front();
                            else e_resp = 8'($urandom);
                            if (e_n >= HDR)
                                exp_rd_q.push_back('{data: e_resp, last: (e_n == HDR + model_len)});
                            e_hold = int'($urandom_range(1, 4));
                            e_st   = 1;
                        end
                    end
                    1: begin
                        check("start_single_cycle", 32'(eng_start), 0);
                        eng_busy = 1'b1;
                        eng_dout = 8'($urandom);
                        e_st     = 2;
                    end
                    default: begin
                        check("start_while_busy", 32'(eng_start), 0);
                        e_hold--;
                        if (e_hold == 0) begin
                            check("din_stable", 32'(eng_din), 32'(e_din));
                            eng_busy = 1'b0;
                            eng_dout = e_resp;
                            e_st     = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Compare process: every negedge, DUT outputs against the model.
    logic    cs_n_prev = 1'b1;
    logic    in_txn    = 1'b0;
    logic    gap_valid = 1'b0;
    logic    hold_active = 1'b0;
    logic    rising;
    logic    falling;
    int      cur_len;
    int      n_start;
    int      n_rd;
    int      setup_cnt;
    int      hold_cnt;
    int      high_cnt;
    rd_exp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_rd_q.delete();
            exp_din_q.delete();
            exp_len_q.delete();
            in_txn      = 1'b0;
            gap_valid   = 1'b0;
            hold_active = 1'b0;
            cs_n_prev   = 1'b1;
            high_cnt    = 0;
            check("rst_cs_n", 32'(cs_n), 1);
            check("rst_rd_valid", 32'(rd_valid), 0);
            check("rst_done", 32'(done), 0);
            check("rst_eng_start", 32'(eng_start), 0);
        end else begin
            rising  = cs_n && !cs_n_prev;
            falling = !cs_n && cs_n_prev;
            if (falling) begin
                check("accept_expected", 32'(exp_len_q.size() != 0), 1);
                if (exp_len_q.size() != 0) cur_len = exp_len_q.pop_front();
                if (gap_valid) check("cs_idle_gap_ok", 32'(high_cnt >= CS_IDLE + 1), 1);
                in_txn      = 1'b1;
                n_start     = 0;
                n_rd        = 0;
                setup_cnt   = 0;
                hold_active = 1'b0;
            end
            check("done_pulse", 32'(done), 32'(rising));
            if (rising) begin
                check("hold_clocks", hold_cnt, CS_HOLD);
                check("start_count", n_start, HDR + cur_len + 1);
                check("rd_count", n_rd, cur_len + 1);
                in_txn      = 1'b0;
                hold_active = 1'b0;
                high_cnt    = 0;
                gap_valid   = 1'b1;
                tot_done++;
            end
            if (cs_n) high_cnt++;
            else check("req_ready_low_while_selected", 32'(req_ready), 0);

            if (eng_start) begin
                check("start_cs_low", 32'(cs_n), 0);
                if (n_start == 0) check("setup_clocks", setup_cnt, CS_SETUP);
                check("din_expected", 32'(exp_din_q.size() != 0), 1);
                if (exp_din_q.size() != 0) check("eng_din", 32'(eng_din), 32'(exp_din_q.pop_front()));
                n_start++;
                tot_start++;
                din_log.push_back(eng_din);
            end else if (in_txn && n_start == 0 && !cs_n) begin
                setup_cnt++;
            end

            if (rd_valid) begin
                check("rd_expected", 32'(exp_rd_q.size() != 0), 1);
                if (exp_rd_q.size() != 0) begin
                    e = exp_rd_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(e.data));
                    check("rd_last", 32'(rd_last), 32'(e.last));
                end
                n_rd++;
                tot_rd++;
                rd_log.push_back(rd_data);
                last_log.push_back(rd_last);
                if (rd_last) begin
                    hold_active = 1'b1;
                    hold_cnt    = 0;
                end
            end else begin
                check("rd_last_without_valid", 32'(rd_last), 0);
            end
            if (hold_active && !cs_n) hold_cnt++;
            cs_n_prev = cs_n;
        end
    end

    task automatic clear_logs();
        din_log.delete();
        rd_log.delete();
        last_log.delete();
    endtask

    task automatic send(input logic [23:0] a, input logic [7:0] l, input bit keep);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(req_ready), 1);
        if (req_ready) begin
            model_len = int'(l);
            exp_len_q.push_back(int'(l));
            exp_din_q.push_back(CMD);
            exp_din_q.push_back(a[23:16]);
            exp_din_q.push_back(a[15:8]);
            exp_din_q.push_back(a[7:0]);
`ifdef SPI_READ_CTRL_FAST_READ_EN
            exp_din_q.push_back(8'h00);
`endif
            for (int i = 0; i <= int'(l); i++) exp_din_q.push_back(8'h00);
        end
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (tot_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(tot_done >= target), 1);
    endtask

    logic [7:0] lit_q[$];
    logic       lit_last_q[$];
    int         d0;
    int         s0;
    int         r0;
    int         r1;
    int         nw;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        #1 rst_n  = 1'b0;
        #1;
        check("reset_cs_n", 32'(cs_n), 1);
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_eng_start", 32'(eng_start), 0);
        check("reset_eng_din", 32'(eng_din), 0);
        check("reset_rd_data", 32'(rd_data), 0);
        check("reset_rd_valid", 32'(rd_valid), 0);
        check("reset_rd_last", 32'(rd_last), 0);
        check("reset_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_low_before_edge", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        check("ready_high_after_edge", 32'(req_ready), 1);

        // Single byte
        clear_logs();
        forced_q.push_back(8'hA5);
        d0 = tot_done;
        send(24'h123456, 8'd0, 1'b0);
        wait_done(d0 + 1, 500);
`ifdef SPI_READ_CTRL_FAST_READ_EN
        lit_q = '{8'h0B, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00};
`else
        lit_q = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00};
`endif
        check("single_din_count", din_log.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < din_log.size(); i++)
            check("single_din_byte", 32'(din_log[i]), 32'(lit_q[i]));
        check("single_rd_count", rd_log.size(), 1);
        if (rd_log.size() != 0) begin
            check("single_rd_data", 32'(rd_log[0]), 'hA5);
            check("single_rd_last", 32'(last_log[0]), 1);
        end
        check("single_done_once", tot_done - d0, 1);

        // Burst of 4
        clear_logs();
        forced_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        d0 = tot_done;
        s0 = tot_start;
        send(24'($urandom), 8'd3, 1'b0);
        wait_done(d0 + 1, 800);
        lit_q      = '{8'h11, 8'h22, 8'h33, 8'h44};
        lit_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        check("burst_starts", tot_start - s0, BURST4_STARTS);
        check("burst_rd_count", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            check("burst_rd_data", 32'(rd_log[i]), 32'(lit_q[i]));
            check("burst_rd_last", 32'(last_log[i]), 32'(lit_last_q[i]));
        end

        // Maximum length
        clear_logs();
        d0 = tot_done;
        s0 = tot_start;
        send(24'hFFFFFF, 8'd255, 1'b0);
        wait_done(d0 + 1, 6000);
        check("max_rd_count", rd_log.size(), 256);
        check("max_starts", tot_start - s0, MAX_STARTS);
        check("max_done_once", tot_done - d0, 1);

`ifdef SPI_READ_CTRL_FAST_READ_EN
        // Fast-read framing
        clear_logs();
        d0 = tot_done;
        send(24'h000000, 8'd0, 1'b0);
        wait_done(d0 + 1, 500);
        lit_q = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check("fast_din_count", din_log.size(), 6);
        for (int i = 0; i < 6 && i < din_log.size(); i++)
            check("fast_din_byte", 32'(din_log[i]), 32'(lit_q[i]));
        check("fast_rd_count", rd_log.size(), 1);
`endif

        // Back-to-back with req_valid held high
        d0 = tot_done;
        send(24'($urandom), 8'($urandom_range(0, 3)), 1'b1);
        send(24'($urandom), 8'($urandom_range(0, 3)), 1'b1);
        send(24'($urandom), 8'($urandom_range(0, 3)), 1'b0);
        wait_done(d0 + 3, 2000);

        // Reset during the second data byte
        d0 = tot_done;
        r0 = tot_rd;
        send(24'hABCDEF, 8'd7, 1'b0);
        nw = 0;
        while (tot_rd == r0 && nw < 3000) begin
            @(negedge clk);
            nw++;
        end
        while (!eng_start && nw < 3000) begin
            @(negedge clk);
            nw++;
        end
        check("mid_reached_second_byte", tot_rd - r0, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs_n), 1);
        check("abort_rd_valid", 32'(rd_valid), 0);
        check("abort_done", 32'(done), 0);
        check("abort_req_ready", 32'(req_ready), 0);
        check("abort_eng_start", 32'(eng_start), 0);
        r1 = tot_rd;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready_before_edge", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        check("abort_ready_after_edge", 32'(req_ready), 1);
        repeat (30) @(negedge clk);
        check("abort_no_more_rd", tot_rd, r1);
        check("abort_no_done", tot_done, d0);

        // Random traffic
        d0 = tot_done;
        for (int t = 0; t < 25; t++) begin
            logic [7:0] l;
            if ($urandom_range(0, 3) == 0) l = 8'($urandom_range(0, 255));
            else l = 8'($urandom_range(0, 12));
            send(24'($urandom), l, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        req_valid = 1'b0;
        wait_done(d0 + 25, 30000);
        repeat (10) @(negedge clk);
        check("model_rd_queue_drained", exp_rd_q.size(), 0);
        check("model_din_queue_drained", exp_din_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_read_ctrl.md
Name: spi_read_ctrl

Overview:
- Transaction sequencer that sits above the existing 8-bit SPI byte engine (divisor/din/dout/start/busy interface).
- Accepts one read request and drives chip-select.
- Issues a read command, a 24-bit address and optional dummy bytes through the byte engine, then streams back req_len+1 data bytes.
- Serves as the flash/EEPROM read front end for the design.

Parameters:
- CMD_READ, 8'h03, command byte sent when FAST_READ_EN is not defined.
- CS_SETUP, 2, clocks from cs_n falling to the first eng_start. Range 1..15.
- CS_HOLD, 2, clocks from the last byte completing to cs_n rising. Range 1..15.
- CS_IDLE, 4, minimum clocks cs_n stays high before the next request is accepted. Range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  read request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_addr  in  24  start byte address, sent MSB first
- req_len  in  8  byte count minus one (0 means 1 byte, 255 means 256 bytes)
- rd_data  out  8  received data byte
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_last  out  1  high together with rd_valid on the final byte
- done  out  1  one-cycle pulse when cs_n returns high
- cs_n  out  1  SPI chip select, active low
- eng_start  out  1  one-cycle start pulse to the byte engine
- eng_din  out  8  byte to transmit, held stable from eng_start until the byte completes
- eng_busy  in  1  byte engine busy
- eng_dout  in  8  byte engine received byte

Behaviour:
- Reset: rst_n=0 asynchronously forces:
  - IDLE state, cs_n=1, req_ready=0 until the first clock edge after release, then 1
  - eng_start=0, eng_din=0, rd_data=0, rd_valid=0, rd_last=0, done=0
  - all counters cleared
- Reset mid-transaction aborts immediately: cs_n=1, no rd_valid and no done.
- Handshake: a request is accepted on the rising edge where req_valid && req_ready. req_addr and req_len are latched. req_ready drops the next cycle.
- States, in order:
  - IDLE: on accept, cs_n<=0, go to SETUP.
  - SETUP: count CS_SETUP clocks, then go to CMD.
  - CMD: send CMD_READ (or 8'h0B with FAST_READ_EN).
  - ADDR: send addr[23:16], then addr[15:8], then addr[7:0].
  - DUMMY: only with FAST_READ_EN; send 8'h00.
  - DATA: send 8'h00 req_len+1 times; each received byte goes to rd_data.
  - HOLD: count CS_HOLD clocks, then cs_n<=1 and pulse done.
  - DESEL: count CS_IDLE clocks, then go to IDLE.
- Byte sub-sequence, used for every byte:
  - ISSUE: eng_start=1 for exactly one cycle, eng_din set.
  - WAIT_HI: wait until eng_busy=1. The engine raises busy 2 clocks after start.
  - WAIT_LO: wait until eng_busy=0. On that first low cycle, eng_dout is valid and is captured.
- Bytes from CMD, ADDR and DUMMY are discarded.
- In DATA, each captured byte:
  - rd_data<=eng_dout, rd_valid pulses 1 cycle.
  - rd_last=1 when the remaining count is 0.
  - There is no backpressure; the consumer must accept every pulse.
- The next ISSUE follows the cycle after capture (back-to-back), keeping cs_n low across all bytes.
- Byte counter: 9-bit count of req_len+1. req_len=255 gives exactly 256 bytes; there is no wrap to 0.
- Address is not incremented by the controller; the device auto-increments.
- req_valid while busy is ignored (req_ready=0). A request is never accepted in the same cycle done pulses.
- Total bytes on the bus: 4 + req_len + 1, or 5 + req_len + 1 with FAST_READ_EN.

Optional Feature:
- Macro: SPI_READ_CTRL_FAST_READ_EN.
- Defined:
  - The command byte is 8'h0B instead of CMD_READ.
  - One DUMMY byte (8'h00, response discarded) is inserted after ADDR.
- Undefined:
  - The DUMMY state is absent and CMD_READ is used.

Test Plan:
- Single byte:
  - Stimulus: addr=24'h123456, len=0, engine model returns 8'hA5 on byte 5.
  - Required: eng_din sequence 03,12,34,56,00; one rd_valid with rd_data=A5 and rd_last=1; done once; cs_n low for the whole burst.
- Burst of 4:
  - Stimulus: len=3, engine returns 11,22,33,44.
  - Required: four rd_valid pulses in order; rd_last only on 44; exactly 8 eng_start pulses.
- Max length:
  - Stimulus: len=255.
  - Required: exactly 256 rd_valid pulses, 260 eng_start pulses, then done.
- Back-to-back requests:
  - Stimulus: req_valid held high.
  - Required: second accept no earlier than CS_HOLD+CS_IDLE+1 clocks after the last capture; cs_n high for at least CS_IDLE clocks.
- Reset mid-DATA:
  - Stimulus: rst_n=0 while on the 2nd data byte.
  - Required: cs_n=1 asynchronously, no further rd_valid, no done; req_ready=1 one clock after release.
- FAST_READ_EN build:
  - Stimulus: addr=0, len=0.
  - Required: eng_din sequence 0B,00,00,00,00,00; rd_valid only on the 6th byte.
